// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boots, fetches sequentially, and handles memory wait, stall, branch and halt.
// Define PC_SEQ_PERF_EN to add the stall_cycles performance counter output.
module pc_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   input  logic        halt,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   output logic [15:0] pc_next,
   output logic        pc_we,
   output logic        insn_valid,
   output logic        halted
`ifdef PC_SEQ_PERF_EN
   ,
   output logic [15:0] stall_cycles
`endif
);

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      FETCH    = 2'd1,
      WAIT_MEM = 2'd2,
      HALTED   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
         pc    <= 16'h0000;
      end else begin
         state <= state_nxt;
         if (pc_we) pc <= pc_next;
      end
   end

   assign imem_addr = pc;

   always_comb begin
      state_nxt  = state;
      imem_req   = 1'b0;
      pc_next    = pc;
      pc_we      = 1'b0;
      insn_valid = 1'b0;
      halted     = 1'b0;
      case (state)
         BOOT: state_nxt = FETCH;
         FETCH, WAIT_MEM: begin
            imem_req = 1'b1;
            // Redirect wins over everything and squashes any word returned this cycle.
            if (branch_taken) begin
               pc_next   = branch_target;
               pc_we     = 1'b1;
               state_nxt = FETCH;
            end else if (stall) begin
               state_nxt = state;
            end else if (!imem_ready) begin
               state_nxt = WAIT_MEM;
            end else begin
               insn_valid = 1'b1;
               if (halt) begin
                  state_nxt = HALTED;
               end else begin
                  pc_next   = pc + 16'd2;
                  pc_we     = 1'b1;
                  state_nxt = FETCH;
               end
            end
         end
         HALTED: halted = 1'b1;
         default: state_nxt = BOOT;
      endcase
   end

`ifdef PC_SEQ_PERF_EN
   logic stall_inc;

   // A WAIT_MEM cycle that is also stalled counts once.
   assign stall_inc = (state == WAIT_MEM) ||
                      ((state == FETCH) && stall && !branch_taken);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= 16'h0000;
      end else if (stall_inc && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected PC-update/accept events, a monitor checks them.
// Build with PC_SEQ_PERF_EN defined to also check stall_cycles.
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic        imem_ready;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        halt;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] pc_next;
   logic        pc_we;
   logic        insn_valid;
   logic        halted;
`ifdef PC_SEQ_PERF_EN
   logic [15:0] stall_cycles;
`endif

   pc_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_ready    (imem_ready),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt          (halt),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .pc_next       (pc_next),
      .pc_we         (pc_we),
      .insn_valid    (insn_valid),
      .halted        (halted)
`ifdef PC_SEQ_PERF_EN
      ,
      .stall_cycles  (stall_cycles)
`endif
   );

   typedef struct {
      logic        we;
      logic [15:0] nxt;
      logic        vld;
      logic [15:0] addr;
   } evt_t;

   evt_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
   endtask

   task automatic push(input logic we, input logic [15:0] nxt, input logic vld, input logic [15:0] addr);
      evt_t e;
      e.we = we; e.nxt = nxt; e.vld = vld; e.addr = addr;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: any cycle with pc_we or insn_valid is an observed event.
   always @(negedge clk) begin
      if (pc_we === 1'b1 || insn_valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got we=%0b nxt=0x%04h vld=%0b addr=0x%04h expected no event",
                     pc_we, pc_next, insn_valid, imem_addr);
         end else begin
            evt_t e;
            e = exp_q.pop_front();
            if (pc_we === e.we && insn_valid === e.vld && imem_addr === e.addr &&
                (!e.we || pc_next === e.nxt)) begin
               n_pass++;
               $display("event ok: we=%0b nxt=0x%04h vld=%0b addr=0x%04h", pc_we, pc_next, insn_valid, imem_addr);
            end else begin
               $display("FAIL event: got we=%0b nxt=0x%04h vld=%0b addr=0x%04h expected we=%0b nxt=0x%04h vld=%0b addr=0x%04h",
                        pc_we, pc_next, insn_valid, imem_addr, e.we, e.nxt, e.vld, e.addr);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; branch_taken = 1'b0;
      branch_target = 16'h0000; halt = 1'b0;
      step();
      chk("rst_imem_req", {15'd0, imem_req}, 16'd0);
      chk("rst_pc_we", {15'd0, pc_we}, 16'd0);
      chk("rst_insn_valid", {15'd0, insn_valid}, 16'd0);
      chk("rst_halted", {15'd0, halted}, 16'd0);
      chk("rst_pc_next", pc_next, 16'h0000);
      chk("rst_imem_addr", imem_addr, 16'h0000);
      step();
      rst_n = 1'b1;
      #1 chk("boot_imem_req", {15'd0, imem_req}, 16'd0);
      // Sequential fetch 0, 2, 4
      step(); push(1'b1, 16'h0002, 1'b1, 16'h0000);
      chk("fetch_imem_req", {15'd0, imem_req}, 16'd1);
      step(); push(1'b1, 16'h0004, 1'b1, 16'h0002);
      // Memory wait at 0x0004
      step(); imem_ready = 1'b0;
      step(); #1 chk("wait1_addr", imem_addr, 16'h0004);
      step(); #1 chk("wait2_addr", imem_addr, 16'h0004);
      chk("wait2_req", {15'd0, imem_req}, 16'd1);
      step(); imem_ready = 1'b1; push(1'b1, 16'h0006, 1'b1, 16'h0004);
      step();
`ifdef PC_SEQ_PERF_EN
      chk("stall_cycles_wait", stall_cycles, 16'd3);
`endif
      // Branch with stall and no memory data
      branch_taken = 1'b1; branch_target = 16'h0100; stall = 1'b1; imem_ready = 1'b0;
      push(1'b1, 16'h0100, 1'b0, 16'h0006);
      step(); branch_taken = 1'b0; stall = 1'b0; imem_ready = 1'b1;
      #1 chk("branch_addr", imem_addr, 16'h0100);
      push(1'b1, 16'h0102, 1'b1, 16'h0100);
      // Stall holds pc
      step(); stall = 1'b1;
      step(); stall = 1'b0;
      #1 chk("stall_hold_addr", imem_addr, 16'h0102);
      push(1'b1, 16'h0104, 1'b1, 16'h0102);
      // Branch to 0xFFFE squashing a ready word, then wrap
      step(); branch_taken = 1'b1; branch_target = 16'hFFFE;
      push(1'b1, 16'hFFFE, 1'b0, 16'h0104);
      step(); branch_taken = 1'b0;
      push(1'b1, 16'h0000, 1'b1, 16'hFFFE);
      step(); branch_taken = 1'b1; branch_target = 16'h0010;
      push(1'b1, 16'h0010, 1'b0, 16'h0000);
      // Halt on accept at 0x0010
      step(); branch_taken = 1'b0; halt = 1'b1;
      push(1'b0, 16'h0010, 1'b1, 16'h0010);
      #1 chk("pre_halt_halted", {15'd0, halted}, 16'd0);
      step(); halt = 1'b0; branch_taken = 1'b1; branch_target = 16'h0200;
      #1 chk("halted", {15'd0, halted}, 16'd1);
      chk("halted_req", {15'd0, imem_req}, 16'd0);
      step(); branch_taken = 1'b0;
      #1 chk("halted_still", {15'd0, halted}, 16'd1);
      chk("halted_addr", imem_addr, 16'h0010);
      // Reset out of HALTED, then reset during WAIT_MEM
      rst_n = 1'b0;
      #1 chk("rst_halted_clr", {15'd0, halted}, 16'd0);
      step(); rst_n = 1'b1;
      step(); push(1'b1, 16'h0002, 1'b1, 16'h0000);
      step(); imem_ready = 1'b0;
      step();
      #1 chk("wm_addr", imem_addr, 16'h0002);
      imem_ready = 1'b1; rst_n = 1'b0;
      #1 chk("wm_rst_addr", imem_addr, 16'h0000);
      chk("wm_rst_req", {15'd0, imem_req}, 16'd0);
      chk("wm_rst_pc_next", pc_next, 16'h0000);
      step(); rst_n = 1'b1;
      #1 chk("reboot_req", {15'd0, imem_req}, 16'd0);
`ifdef PC_SEQ_PERF_EN
      chk("stall_cycles_rst", stall_cycles, 16'd0);
`endif
      step(); push(1'b1, 16'h0002, 1'b1, 16'h0000);
      step(); push(1'b1, 16'h0004, 1'b1, 16'h0002);
      step(); imem_ready = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending events expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
